// File: rtl/fp32_norm_round.sv
// fp32_norm_round: normalise a 49-bit mantissa product sum and round it to
// an IEEE-754 single-precision result. Round-to-nearest-even; denormals
// flush to zero.
//   S1: leading-one detect, left-align, exponent adjust.
//   S2: round, range check, pack, output register.
// Each stage has a valid bit and a ready/valid handshake. A stalled output
// holds S2, and S1 holds behind it.
module fp32_norm_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_sum,
    input  logic        in_cout,
    input  logic [9:0]  in_exp,
    input  logic        in_sign,
    input  logic        in_nan,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic        s1_valid;
    logic        s2_adv;
    logic        s1_adv;

    // S2 is the output register, so its valid bit is out_valid
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // ------------------------------------------------------------------
    // S1 combinational: leading-one detect, alignment, exponent adjust
    // ------------------------------------------------------------------
    logic [48:0] v;
    logic [5:0]  lead;
    logic        v_zero;
    logic [5:0]  shamt;
    logic [48:0] v_shifted;
    logic [47:0] frac_aligned;
    logic [10:0] exp_adj;

    assign v = {in_cout, in_sum};

    // Priority encoder: the ascending scan leaves the highest set bit in lead
    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < 49; i++) begin
            if (v[i]) begin
                lead = 6'(i);
            end
        end
    end

    assign v_zero    = (v == '0);
    assign shamt     = 6'd48 - lead;
    assign v_shifted = v << shamt;
    // Bit 48 of the aligned value is the implicit leading one, so it is not stored
    assign frac_aligned = v_shifted[47:0];
    // E = in_exp + (k - 46). Modular 11-bit arithmetic on the sign-extended
    // exponent gives the same bits as signed arithmetic.
    assign exp_adj = {in_exp[9], in_exp} + {5'd0, lead} - 11'd46;

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic [47:0] s1_frac;
    logic [10:0] s1_exp;
    logic        s1_sign;
    logic        s1_nan;
    logic        s1_inf;
    logic        s1_zero;

    // S1 stage register: loads a new beat or empties whenever S2 can take its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_frac  <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_frac <= frac_aligned;
                s1_exp  <= exp_adj;
                s1_sign <= in_sign;
                s1_nan  <= in_nan;
                s1_inf  <= in_inf;
                s1_zero <= v_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: round, range check, pack
    // ------------------------------------------------------------------
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [22:0] mant_r;
    logic [10:0] exp_r;
    logic        exp_ovf;
    logic        exp_unf;

    assign mant     = s1_frac[47:25];
    assign guard    = s1_frac[24];
    assign sticky   = |s1_frac[23:0];
    assign round_up = guard && (sticky || mant[0]);
    assign mant_sum = {1'b0, mant} + {23'd0, round_up};
    // A carry out of the mantissa leaves mant_sum[22:0] at zero, which is
    // the mantissa of the next binade.
    assign mant_r   = mant_sum[22:0];
    assign exp_r    = s1_exp + {10'd0, mant_sum[23]};
    assign exp_ovf  = $signed(exp_r) >= $signed(11'd255);
    assign exp_unf  = $signed(exp_r) <= $signed(11'd0);

    logic [31:0] res_nxt;
    logic        ovf_nxt;
    logic        unf_nxt;
    logic        inx_nxt;

    // Result selection in precedence order: NaN, Inf, zero, then range check
    always_comb begin
        res_nxt = '0;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        inx_nxt = 1'b0;
        if (s1_nan) begin
            res_nxt = 32'h7FC0_0000;
        end else if (s1_inf) begin
            res_nxt = {s1_sign, 31'h7F80_0000};
        end else if (s1_zero) begin
            res_nxt = {s1_sign, 31'd0};
        end else if (exp_ovf) begin
            res_nxt = {s1_sign, 31'h7F80_0000};
            ovf_nxt = 1'b1;
            inx_nxt = 1'b1;
        end else if (exp_unf) begin
            res_nxt = {s1_sign, 31'd0};
            unf_nxt = 1'b1;
            inx_nxt = 1'b1;
        end else begin
            res_nxt = {s1_sign, exp_r[7:0], mant_r};
            inx_nxt = guard || sticky;
        end
    end

    // ------------------------------------------------------------------
    // S2 / output register
    // ------------------------------------------------------------------
    // Output register: advances when empty or consumed, otherwise holds every out_* signal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= res_nxt;
                out_overflow  <= ovf_nxt;
                out_underflow <= unf_nxt;
                out_inexact   <= inx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fp32_norm_round.sv
// Bench for fp32_norm_round: directed vectors with hand-computed results,
// an arithmetic reference model, and a scoreboard monitor that compares
// every consumed output beat and checks stability while stalled.
module tb_fp32_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_sum = '0;
    logic        in_cout = 1'b0;
    logic [9:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp32_norm_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_exp(in_exp), .in_sign(in_sign),
        .in_nan(in_nan), .in_inf(in_inf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: value = V * 2^(in_exp - 127 - 46). The result is
    // {result, ovf, unf, inexact}, derived with integer division/remainder.
    function automatic logic [34:0] model(input logic [47:0] sum, input logic cout,
                                          input logic [9:0] exp10, input logic sign,
                                          input logic nan, input logic inf);
        logic [63:0] v;
        logic [63:0] q;
        logic [63:0] r;
        logic [63:0] half;
        int k;
        int e;
        int sh;
        logic up;
        logic inexact;
        logic signed [9:0] es;
        v = {15'd0, cout, sum};
        if (nan) return {32'h7FC00000, 3'b000};
        if (inf) return {sign, 31'h7F800000, 3'b000};
        if (v == 0) return {sign, 31'd0, 3'b000};
        k = 0;
        while ((v >> (k + 1)) != 0) k++;
        es = exp10;
        e = int'(es) + k - 46;
        if (k >= 24) begin
            sh = k - 23;
            q = v >> sh;
            r = v - (q << sh);
            half = 64'd1 << (sh - 1);
            up = (r > half) || (r == half && q[0]);
            inexact = (r != 0);
        end else begin
            q = v << (23 - k);
            up = 1'b0;
            inexact = 1'b0;
        end
        q = q + {63'd0, up};
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {sign, 31'h7F800000, 3'b101};
        if (e <= 0) return {sign, 31'd0, 3'b011};
        return {sign, 8'(e), q[22:0], 2'b00, inexact};
    endfunction

    // Scoreboard monitor, sampling on the falling edge
    logic [34:0] exp_q[$];
    int accepted = 0;
    logic        prev_stall = 1'b0;
    logic [34:0] prev_out;

    // Sample the handshakes, push expected beats, and compare every consumed output
    always @(negedge clk) begin
        logic [34:0] cur;
        logic [34:0] e;
        cur = {out_result, out_overflow, out_underflow, out_inexact};
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", {63'd0, out_valid}, 64'd1);
                check("stall_out_hold", {29'd0, cur}, {29'd0, prev_out});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_sum, in_cout, in_exp, in_sign, in_nan, in_inf));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {29'd0, cur}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_result_flags", {29'd0, cur}, {29'd0, e});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = cur;
        end
    end

    // Directed vectors: sum, cout, exp, sign, nan, inf, expected {result, ovf, unf, inx}
    typedef struct {
        logic [47:0] sum;
        logic        cout;
        logic [9:0]  exp10;
        logic        sign;
        logic        nan;
        logic        inf;
        logic [34:0] expv;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{48'h400000000000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h3F800000, 3'b000}};
        vecs[1]  = '{48'h900000000000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h40100000, 3'b000}};
        vecs[2]  = '{48'h400000400000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h3F800000, 3'b001}};
        vecs[3]  = '{48'h400000C00000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h3F800002, 3'b001}};
        vecs[4]  = '{48'h800000000000, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, {32'h7F800000, 3'b101}};
        vecs[5]  = '{48'h400000000000, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0, {32'h00000000, 3'b011}};
        vecs[6]  = '{48'h123456789ABC, 1'b0, 10'd127, 1'b0, 1'b1, 1'b1, {32'h7FC00000, 3'b000}};
        vecs[7]  = '{48'h000000000000, 1'b1, 10'd127, 1'b0, 1'b0, 1'b0, {32'h40800000, 3'b000}};
        vecs[8]  = '{48'h7FFFFFC00000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h40000000, 3'b001}};
        vecs[9]  = '{48'h000000000000, 1'b0, 10'd127, 1'b1, 1'b0, 1'b0, {32'h80000000, 3'b000}};
        vecs[10] = '{48'h400000000000, 1'b0, 10'd127, 1'b1, 1'b0, 1'b1, {32'hFF800000, 3'b000}};
        vecs[11] = '{48'h000000000001, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h28800000, 3'b000}};
        vecs[12] = '{48'h400000000000, 1'b0, 10'd1,   1'b0, 1'b0, 1'b0, {32'h00800000, 3'b000}};
        vecs[13] = '{48'h400000000000, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, {32'h7F000000, 3'b000}};
        vecs[14] = '{48'h400000000000, 1'b0, 10'h3FB, 1'b1, 1'b0, 1'b0, {32'h80000000, 3'b011}};
        vecs[15] = '{48'h7FFFFFC00000, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, {32'h7F800000, 3'b101}};
        vecs[16] = '{48'h400000000000, 1'b0, 10'd127, 1'b1, 1'b1, 1'b0, {32'h7FC00000, 3'b000}};
        vecs[17] = '{48'h400000400001, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h3F800001, 3'b001}};
    end

    task automatic drive(input int idx);
        in_sum   = vecs[idx].sum;
        in_cout  = vecs[idx].cout;
        in_exp   = vecs[idx].exp10;
        in_sign  = vecs[idx].sign;
        in_nan   = vecs[idx].nan;
        in_inf   = vecs[idx].inf;
        in_valid = 1'b1;
    endtask

    // Offer one beat and hold it until it is accepted, within a cycle budget
    task automatic send(input int idx);
        logic acc;
        int n;
        drive(idx);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Pin the reference model to the hand-computed expectations
        #1;
        for (int i = 0; i < 18; i++) begin
            check($sformatf("model_pin_%0d", i),
                  {29'd0, model(vecs[i].sum, vecs[i].cout, vecs[i].exp10,
                                vecs[i].sign, vecs[i].nan, vecs[i].inf)},
                  {29'd0, vecs[i].expv});
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_word", {29'd0, out_result, out_overflow, out_underflow, out_inexact}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted beat shows up two cycles after being presented
        drive(0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_not_yet", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", {63'd0, out_valid}, 64'd1);
        check("lat_result", {32'd0, out_result}, 64'h3F800000);
        check("lat_flags", {61'd0, out_overflow, out_underflow, out_inexact}, 64'd0);
        @(posedge clk);
        #1;

        // All vectors back to back
        for (int i = 0; i < 18; i++) send(i);
        drain();

        // Backpressure: four beats offered with the output stalled
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(1); send(2); send(3); send(4);
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        check("bp_accepted", 64'(accepted), 64'd2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_head_result", {32'd0, out_result}, 64'h40100000);
        out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_total_accepted", 64'(accepted), 64'd4);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(7);
        send(8);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_word", {29'd0, out_result, out_overflow, out_underflow, out_inexact}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("postrst_no_stale", {63'd0, out_valid}, 64'd0);
        end

        // NaN together with Inf, after reset
        send(6);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp32_norm_round.md
FP32_NORM_ROUND -- requirements
Module: fp32_norm_round

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block can accept an input beat this cycle.
REQ-007 in_sum  input  48  mantissa product sum from the 48-bit adder stage.
REQ-008 in_cout  input  1  adder carry out, treated as bit 48 of V = {in_cout, in_sum}.
REQ-009 in_exp  input  10  two's-complement biased exponent (ea + eb - 127), valid for V with its leading one at bit 46.
REQ-010 in_sign  input  1  result sign.
REQ-011 in_nan, in_inf  input  1 each  special-operand flags from the operand decoder.
REQ-012 out_valid  output  1  result beat valid.
REQ-013 out_ready  input  1  consumer accepts the result beat.
REQ-014 out_result  output  32  packed IEEE-754 single-precision result.
REQ-015 out_overflow, out_underflow, out_inexact  output  1 each  status flags for out_result.

Function
REQ-016 The block SHALL have two pipeline stages: S1 (leading-one detect, shift, exponent adjust) and S2 (round, range check, pack, output register).
REQ-017 Each stage SHALL hold a valid bit; a beat transfers on in_valid && in_ready and on out_valid && out_ready.
REQ-018 in_ready SHALL be !s1_valid || !s2_valid || out_ready, giving one beat per cycle with no bubbles.
REQ-019 Latency from input acceptance to out_valid SHALL be 2 cycles when there is no stall.
REQ-020 While out_valid && !out_ready, all out_* signals SHALL hold stable, and S1 SHALL hold if it is occupied.
REQ-021 Beats SHALL emerge in acceptance order; no beat is dropped or duplicated.
REQ-022 S1 SHALL locate the leading one k of the 49-bit V (priority encoder over bits 48..0).
REQ-023 S1 SHALL compute E = in_exp + (k - 46) in 11-bit signed arithmetic, and left-align V so that bit k maps to bit 48.
REQ-024 S2 mantissa SHALL be the 23 bits below the leading one, with guard = next bit and sticky = OR of all remaining bits.
REQ-025 Rounding SHALL be round-to-nearest-even: increment when guard && (sticky || mantissa LSB); inexact = guard || sticky.
REQ-026 A rounding carry out of the mantissa SHALL set the mantissa to 0 and E = E + 1.
REQ-027 Result precedence: in_nan -> 0x7FC00000; else in_inf -> {sign, 0x7F800000}; else V == 0 -> {sign, 31'b0}; else range check.
REQ-028 Overflow: final E >= 255 -> {sign, 0x7F800000}, with out_overflow = 1 and out_inexact = 1.
REQ-029 Underflow: final E <= 0 -> {sign, 31'b0} (flush, no denormals), with out_underflow = 1 and out_inexact = 1.
REQ-030 Otherwise the result SHALL be {sign, E[7:0], mantissa}.
REQ-031 For NaN, Inf and zero results, all three flags SHALL be 0.

Reset
REQ-032 When rst_n is low: s1_valid, s2_valid and out_valid SHALL be 0, out_result SHALL be 0x00000000, all flags SHALL be 0, and in_ready SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL discard in-flight beats immediately; no discarded beat may appear after rst_n is released.

Verification
REQ-034 Scenario: in_sum = 0x400000000000, in_exp = 127, sign = 0 -> out_result = 0x3F800000 two cycles later, all flags 0.
REQ-035 Scenario: in_sum = 0x900000000000 (1.5 x 1.5), in_exp = 127 -> out_result = 0x40100000, inexact = 0.
REQ-036 Scenario, RNE tie: in_sum = 0x400000400000, exp 127 -> 0x3F800000, inexact = 1; in_sum = 0x400000C00000 -> 0x3F800002, inexact = 1.
REQ-037 Scenario, range: in_sum bit 47 set, in_exp = 254 -> 0x7F800000, overflow = 1; in_sum = 0x400000000000, in_exp = 0 -> 0x00000000, underflow = 1.
REQ-038 Scenario, backpressure: out_ready held low while four beats are offered back to back -> two beats accepted, in_ready = 0, out_* stable; on releasing out_ready, all four beats emerge in order.
REQ-039 Scenario, reset and specials: rst_n pulsed low with two beats in flight -> out_valid = 0 at once and no stale output afterwards; in_nan && in_inf -> 0x7FC00000.
